// File: rtl/id_ex_stage_reg.sv
// ID->EX pipeline register with valid bit, stall (hold) and flush (bubble).
// Optional stall/flush performance counters are enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int CTRL_W = 20,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              I_IDEX_Stall,
  input  logic              I_IDEX_Flush,
  input  logic              I_IDEX_Valid,
  input  logic [CTRL_W-1:0] I_IDEX_ControlReg,
  input  logic [DATA_W-1:0] I_IDEX_PC,
  input  logic [DATA_W-1:0] I_IDEX_ReadData1,
  input  logic [DATA_W-1:0] I_IDEX_ReadData2,
  input  logic [DATA_W-1:0] I_IDEX_SignExt,
  input  logic [DATA_W-1:0] I_IDEX_SHIFT,
  input  logic [REG_W-1:0]  I_IDEX_RS,
  input  logic [REG_W-1:0]  I_IDEX_RT,
  input  logic [REG_W-1:0]  I_IDEX_RD,
  output logic              O_IDEX_Valid,
  output logic [CTRL_W-1:0] O_IDEX_ControlReg,
  output logic [DATA_W-1:0] O_IDEX_PC,
  output logic [DATA_W-1:0] O_IDEX_ReadData1,
  output logic [DATA_W-1:0] O_IDEX_ReadData2,
  output logic [DATA_W-1:0] O_IDEX_SignExt,
  output logic [DATA_W-1:0] O_IDEX_SHIFT,
  output logic [REG_W-1:0]  O_IDEX_RS,
  output logic [REG_W-1:0]  O_IDEX_RT,
  output logic [REG_W-1:0]  O_IDEX_RD,
  output logic [CNT_W-1:0]  O_IDEX_StallCnt,
  output logic [CNT_W-1:0]  O_IDEX_FlushCnt
);

  // Flush beats stall; a flushed slot is fully zeroed so bubbles are deterministic.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      O_IDEX_Valid      <= 1'b0;
      O_IDEX_ControlReg <= '0;
      O_IDEX_PC         <= '0;
      O_IDEX_ReadData1  <= '0;
      O_IDEX_ReadData2  <= '0;
      O_IDEX_SignExt    <= '0;
      O_IDEX_SHIFT      <= '0;
      O_IDEX_RS         <= '0;
      O_IDEX_RT         <= '0;
      O_IDEX_RD         <= '0;
    end else if (I_IDEX_Flush) begin
      O_IDEX_Valid      <= 1'b0;
      O_IDEX_ControlReg <= '0;
      O_IDEX_PC         <= '0;
      O_IDEX_ReadData1  <= '0;
      O_IDEX_ReadData2  <= '0;
      O_IDEX_SignExt    <= '0;
      O_IDEX_SHIFT      <= '0;
      O_IDEX_RS         <= '0;
      O_IDEX_RT         <= '0;
      O_IDEX_RD         <= '0;
    end else if (!I_IDEX_Stall) begin
      O_IDEX_Valid      <= I_IDEX_Valid;
      // Invalid slots carry no control so they cannot cause side effects downstream.
      O_IDEX_ControlReg <= I_IDEX_Valid ? I_IDEX_ControlReg : '0;
      O_IDEX_PC         <= I_IDEX_PC;
      O_IDEX_ReadData1  <= I_IDEX_ReadData1;
      O_IDEX_ReadData2  <= I_IDEX_ReadData2;
      O_IDEX_SignExt    <= I_IDEX_SignExt;
      O_IDEX_SHIFT      <= I_IDEX_SHIFT;
      O_IDEX_RS         <= I_IDEX_RS;
      O_IDEX_RT         <= I_IDEX_RT;
      O_IDEX_RD         <= I_IDEX_RD;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating counters; a flushed edge never counts as a stall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (I_IDEX_Flush) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end else if (I_IDEX_Stall) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign O_IDEX_StallCnt = stall_cnt;
  assign O_IDEX_FlushCnt = flush_cnt;
`else
  assign O_IDEX_StallCnt = '0;
  assign O_IDEX_FlushCnt = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: stimulus pushes expected state, monitor pops and compares.
module tb_id_ex_stage_reg;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [19:0] ctrl = '0;
  logic [31:0] pc = '0, rd1 = '0, rd2 = '0, se = '0, sh = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;

  logic        o_valid;
  logic [19:0] o_ctrl;
  logic [31:0] o_pc, o_rd1, o_rd2, o_se, o_sh;
  logic [4:0]  o_rs, o_rt, o_rd;
  logic [3:0]  o_scnt, o_fcnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  id_ex_stage_reg #(.CTRL_W(20), .DATA_W(32), .REG_W(5), .CNT_W(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .I_IDEX_Stall(stall), .I_IDEX_Flush(flush), .I_IDEX_Valid(valid),
    .I_IDEX_ControlReg(ctrl), .I_IDEX_PC(pc),
    .I_IDEX_ReadData1(rd1), .I_IDEX_ReadData2(rd2),
    .I_IDEX_SignExt(se), .I_IDEX_SHIFT(sh),
    .I_IDEX_RS(rs), .I_IDEX_RT(rt), .I_IDEX_RD(rd),
    .O_IDEX_Valid(o_valid), .O_IDEX_ControlReg(o_ctrl), .O_IDEX_PC(o_pc),
    .O_IDEX_ReadData1(o_rd1), .O_IDEX_ReadData2(o_rd2),
    .O_IDEX_SignExt(o_se), .O_IDEX_SHIFT(o_sh),
    .O_IDEX_RS(o_rs), .O_IDEX_RT(o_rt), .O_IDEX_RD(o_rd),
    .O_IDEX_StallCnt(o_scnt), .O_IDEX_FlushCnt(o_fcnt)
  );

  typedef struct {
    logic        v;
    logic [19:0] ctrl;
    logic [31:0] pc, rd1, rd2, se, sh;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  scnt, fcnt;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t zero_e;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %h expected %h at %0t", tag, name, act, exp, $time);
    end
  endtask

  task automatic cmp(input exp_t e, input string tag);
    chk("valid", tag, {31'b0, o_valid}, {31'b0, e.v});
    chk("ctrl",  tag, {12'b0, o_ctrl}, {12'b0, e.ctrl});
    chk("pc",    tag, o_pc,  e.pc);
    chk("rd1",   tag, o_rd1, e.rd1);
    chk("rd2",   tag, o_rd2, e.rd2);
    chk("se",    tag, o_se,  e.se);
    chk("sh",    tag, o_sh,  e.sh);
    chk("rs",    tag, {27'b0, o_rs}, {27'b0, e.rs});
    chk("rt",    tag, {27'b0, o_rt}, {27'b0, e.rt});
    chk("rd",    tag, {27'b0, o_rd}, {27'b0, e.rd});
    chk("scnt",  tag, {28'b0, o_scnt}, {28'b0, e.scnt});
    chk("fcnt",  tag, {28'b0, o_fcnt}, {28'b0, e.fcnt});
  endtask

  // Drive one cycle of inputs and queue the register state expected after the next edge.
  task automatic step(input logic s, input logic f, input logic v,
                      input logic [19:0] c, input logic [31:0] p, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    @(negedge CLK);
    stall = s; flush = f; valid = v; ctrl = c; pc = p; rd1 = d1; rd2 = d2;
    se = x; sh = y; rs = a; rt = b; rd = d;
    if (f) begin
      m.v = 1'b0; m.ctrl = '0; m.pc = '0; m.rd1 = '0; m.rd2 = '0; m.se = '0; m.sh = '0;
      m.rs = '0; m.rt = '0; m.rd = '0;
`ifdef IDEX_PERF_CNT_EN
      if (m.fcnt != 4'hF) m.fcnt = m.fcnt + 4'd1;
`endif
    end else if (s) begin
`ifdef IDEX_PERF_CNT_EN
      if (m.scnt != 4'hF) m.scnt = m.scnt + 4'd1;
`endif
    end else begin
      m.v = v; m.ctrl = v ? c : 20'h0; m.pc = p; m.rd1 = d1; m.rd2 = d2; m.se = x; m.sh = y;
      m.rs = a; m.rt = b; m.rd = d;
    end
    q.push_back(m);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic reset_pulse();
    @(posedge CLK);
    #3 RESET_N = 1'b0;
    #1 cmp(zero_e, "reset_mid");
    RESET_N = 1'b1;
    m = zero_e;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp(e, "edge");
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    zero_e = '{v: 1'b0, ctrl: '0, pc: '0, rd1: '0, rd2: '0, se: '0, sh: '0,
               rs: '0, rt: '0, rd: '0, scnt: '0, fcnt: '0};
    m = zero_e;
    #2 cmp(zero_e, "reset_init");
    stall = 1'b1; flush = 1'b1; valid = 1'b1; ctrl = 20'hFFFFF; pc = 32'hFFFF_FFFF;
    rd1 = 32'h1; rd2 = 32'h2; se = 32'h3; sh = 32'h4; rs = 5'd1; rt = 5'd2; rd = 5'd3;
    #1 cmp(zero_e, "reset_held");
    RESET_N = 1'b1;

    // normal load
    step(0, 0, 1, 20'hABCDE, 32'h40, 32'h1111_2222, 32'h3333_4444, 32'hFFFF_FF80, 32'h5, 5'd5, 5'd6, 5'd7);
    // load 0x44, then three stalls while inputs move to 0x48, then release
    step(0, 0, 1, 20'h00011, 32'h44, 32'hA, 32'hB, 32'hC, 32'h1, 5'd8, 5'd9, 5'd10);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 20'h00022, 32'h48, 32'hAA, 32'hBB, 32'hCC, 32'h2, 5'd11, 5'd12, 5'd13);
    step(0, 0, 1, 20'h00022, 32'h48, 32'hAA, 32'hBB, 32'hCC, 32'h2, 5'd11, 5'd12, 5'd13);
    // flush and stall together
    step(1, 1, 1, 20'hFFFFF, 32'h4C, 32'h5, 32'h6, 32'h7, 32'h8, 5'd1, 5'd2, 5'd3);
    // invalid slot keeps data, drops control
    step(0, 0, 0, 20'h12345, 32'h50, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h1, 32'h1F, 5'd31, 5'd30, 5'd29);
    // flush alone, then reload
    step(0, 1, 1, 20'h0F0F0, 32'h54, 32'h9, 32'h9, 32'h9, 32'h9, 5'd4, 5'd4, 5'd4);
    step(0, 0, 1, 20'h0F0F0, 32'h58, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h10, 5'd0, 5'd31, 5'd16);
    reset_pulse();
    // twenty stalls: counter saturates at 15
    for (int i = 0; i < 20; i++)
      step(1, 0, 1, 20'h33333, 32'h60 + 32'(i), 32'h1, 32'h2, 32'h3, 32'h4, 5'd5, 5'd6, 5'd7);
    step(0, 0, 1, 20'h44444, 32'h64, 32'h12, 32'h34, 32'h56, 32'h3, 5'd2, 5'd3, 5'd4);
    step(1, 0, 0, 20'h55555, 32'h68, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Parametrised ID→EX pipeline register for the MIPS core.
- Captures decode-stage control word, PC, register operands, sign-extended immediate, shift amount and RS/RT/RD indices once per cycle.
- Adds a per-stage valid bit, stall (hold) and flush (bubble insertion) so the hazard unit can freeze or squash the EX stage.
- Sits between the register-file/decode logic and the ALU/forwarding logic.

Parameters:
CTRL_W, 20, width of control word
DATA_W, 32, width of PC, operands, immediate and shift fields
REG_W, 5, width of register indices RS/RT/RD
CNT_W, 16, width of performance counters (used only with the optional feature)

Ports:
CLK  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
I_IDEX_Stall  in  1  hold all outputs this cycle
I_IDEX_Flush  in  1  load a bubble this cycle
I_IDEX_Valid  in  1  ID stage holds a real instruction
I_IDEX_ControlReg  in  CTRL_W  decoded control word
I_IDEX_PC  in  DATA_W  PC+4 of instruction
I_IDEX_ReadData1  in  DATA_W  register file port 1
I_IDEX_ReadData2  in  DATA_W  register file port 2
I_IDEX_SignExt  in  DATA_W  sign-extended immediate
I_IDEX_SHIFT  in  DATA_W  shift amount field, zero-extended
I_IDEX_RS / I_IDEX_RT / I_IDEX_RD  in  REG_W  register indices
O_IDEX_Valid  out  1  EX stage holds a real instruction
O_IDEX_ControlReg  out  CTRL_W  registered control word
O_IDEX_PC, O_IDEX_ReadData1, O_IDEX_ReadData2, O_IDEX_SignExt, O_IDEX_SHIFT  out  DATA_W  registered data
O_IDEX_RS / O_IDEX_RT / O_IDEX_RD  out  REG_W  registered indices
O_IDEX_StallCnt  out  CNT_W  stalled-cycle count (optional feature only)
O_IDEX_FlushCnt  out  CNT_W  flush count (optional feature only)

Behaviour:
- RESET_N low, asynchronous: every output goes to 0, including O_IDEX_Valid and the counters. This applies mid-operation with no regard to stall or flush.
- Reset deassertion is synchronised externally. The first capture occurs on the first rising edge with RESET_N high.
- Latency is 1 cycle. Inputs present before edge N appear on the outputs after edge N.
- Per-edge priority, highest first:
  - Flush: O_IDEX_Valid=0 and O_IDEX_ControlReg=0. All data and index outputs are also set to 0 so a bubble is deterministic.
  - Stall (no flush): every output holds its value. Valid is unchanged.
  - Neither: all fields load from inputs. O_IDEX_Valid<=I_IDEX_Valid.
- Flush and stall together: flush wins. A bubble is inserted and the stalled instruction is discarded.
- If I_IDEX_Valid=0 on a normal load, O_IDEX_ControlReg is forced to 0. Data fields still load. This prevents write-back or memory side effects from invalid slots.
- All fields, RS included, are captured in the same cycle. No field is captured independently.
- Stall asserted for K consecutive cycles: outputs remain constant for K edges, then load on the first non-stall edge.
- No combinational path from inputs to outputs.

Optional Feature:
Macro IDEX_PERF_CNT_EN.
- Defined:
  - O_IDEX_StallCnt increments on each edge where I_IDEX_Stall=1 and I_IDEX_Flush=0.
  - O_IDEX_FlushCnt increments on each edge where I_IDEX_Flush=1.
  - Both are CNT_W wide and saturate at all-ones, with no wrap.
  - Both clear on reset.
- Not defined: both ports exist but are tied to 0. No counter flops are synthesised.

Test Plan:
- Reset: drive all inputs non-zero, pulse RESET_N low between clock edges → all outputs 0 immediately, before the next edge.
- Normal pipeline: ControlReg=20'hABCDE, PC=0x0000_0040, RS=5, RT=6, RD=7, Valid=1 → after one edge, outputs equal inputs and O_IDEX_Valid=1. O_IDEX_RS=5 specifically.
- Stall: load PC=0x44, then assert Stall for 3 edges while inputs change to PC=0x48 → PC stays 0x44 for 3 edges, becomes 0x48 on the 4th; StallCnt=3 with IDEX_PERF_CNT_EN.
- Flush and stall same cycle: Flush=1, Stall=1, inputs valid with ControlReg=20'hFFFFF → ControlReg=0, Valid=0, PC=0; FlushCnt=1 and StallCnt unchanged.
- Invalid slot: Valid=0, ControlReg=20'h12345, ReadData1=0xDEAD_BEEF → ControlReg=0, ReadData1=0xDEAD_BEEF, O_IDEX_Valid=0.
- Saturation (CNT_W=4, macro on): 20 consecutive stall edges → StallCnt=15, and it stays 15.
